// File: rtl/byte_fifo.sv
// byte_fifo: small show-ahead (first-word-fall-through) synchronous FIFO.
//
// A producer pushes W-bit words. The consumer reads the head word on dout
// and pops it in the same cycle that it latches the word. The head word is
// valid on dout whenever empty is low.
//
// Ports
//   clk        single clock; all state updates on its rising edge
//   rst        asynchronous, active-high reset; clears all state at once
//   din        write data, sampled when a push is accepted
//   push       write request
//   pop        read request; removes the head entry when accepted
//   clr_err    synchronous clear of the sticky error flags
//   dout       head entry; meaningful only while empty is low
//   empty      high when count == 0
//   full       high when count == DEPTH
//   count      number of stored entries, 0..DEPTH
//   overflow   sticky; set by a push that was rejected
//   underflow  sticky; set by a pop that was rejected
//
// DEPTH must be a power of two and at least 2. Under that condition the
// read and write pointers wrap from DEPTH-1 back to 0 without any extra logic.

module byte_fifo #(
    parameter  int W     = 8,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  din,
    input  logic          push,
    input  logic          pop,
    input  logic          clr_err,
    output logic [W-1:0]  dout,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count,
    output logic          overflow,
    output logic          underflow
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count_q;
    logic          push_ok;
    logic          pop_ok;

    // Flags are decoded from the registered count, so they cannot glitch.
    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;

    // When the FIFO is full, a pop in the same cycle frees the head slot.
    // The incoming word goes into that slot, because wr_ptr == rd_ptr.
    // When the FIFO is empty, there is no bypass path, so the pop is refused.
    assign push_ok = push & (~full | pop);
    assign pop_ok  = pop & ~empty;

    // Show-ahead read port. Reset zeroes the storage, so dout reads 0 after reset.
    assign dout = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    // The count is kept in its own register rather than derived from the
    // pointers. This keeps full and empty apart when rd_ptr == wr_ptr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            unique case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky error flags. If a new error arrives in the same cycle as clr_err,
    // the new error wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (push & ~push_ok) | (overflow  & ~clr_err);
            underflow <= (pop  & ~pop_ok)  | (underflow & ~clr_err);
        end
    end

endmodule

// File: tb/tb_byte_fifo.sv
// Bench for byte_fifo. It uses a queue-based reference model, checks every
// cycle, runs directed scenarios with literal expectations, and finishes with
// a randomized stream that includes asynchronous resets.

module tb_byte_fifo;

    localparam int W     = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  din = '0;
    logic          push = 1'b0;
    logic          pop = 1'b0;
    logic          clr_err = 1'b0;
    logic [W-1:0]  dout;
    logic          empty;
    logic          full;
    logic [CW-1:0] count;
    logic          overflow;
    logic          underflow;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    logic [W-1:0] q[$];
    logic         m_ovf = 1'b0;
    logic         m_unf = 1'b0;

    byte_fifo #(.W(W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .din(din), .push(push), .pop(pop),
        .clr_err(clr_err), .dout(dout), .empty(empty), .full(full),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: plain queue semantics.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            automatic bit can_push = push && (q.size() < DEPTH || pop);
            automatic bit can_pop  = pop && (q.size() > 0);
            if (can_pop)  void'(q.pop_front());
            if (can_push) q.push_back(din);
            m_ovf = (push && !can_push) || (m_ovf && !clr_err);
            m_unf = (pop && !can_pop)   || (m_unf && !clr_err);
        end
    end

    // Per-cycle compare, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            chk("count", 32'(count), 32'(q.size()));
            chk("empty", 32'(empty), 32'(q.size() == 0));
            chk("full", 32'(full), 32'(q.size() == DEPTH));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("underflow", 32'(underflow), 32'(m_unf));
            if (q.size() > 0) chk("dout", 32'(dout), 32'(q[0]));
        end
    end

    // Drive one clock cycle of inputs, and return 1ns after the rising edge.
    task automatic cyc(input logic p, input logic [W-1:0] d, input logic po, input logic c);
        push = p; din = d; pop = po; clr_err = c;
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; clr_err = 1'b0;
    endtask

    task automatic do_reset_pulse();
        #2 rst = 1'b1;
        @(negedge clk);
        #1 rst = 1'b0;
    endtask

    logic [W-1:0] fill_vals [4];
    logic [W-1:0] exp_seq [$];

    initial begin
        fill_vals[0] = 8'h11; fill_vals[1] = 8'h22;
        fill_vals[2] = 8'h33; fill_vals[3] = 8'h44;

        @(negedge clk);
        #1 rst = 1'b0;

        // Reset in the middle of a stream
        cyc(0, 8'h00, 1, 0);
        chk("pre_reset_underflow", 32'(underflow), 32'h1);
        cyc(1, 8'h01, 0, 0);
        cyc(1, 8'h02, 0, 0);
        cyc(1, 8'h03, 0, 0);
        chk("pre_reset_count", 32'(count), 32'd3);
        #2 rst = 1'b1;
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_dout", 32'(dout), 32'h0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_underflow", 32'(underflow), 32'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        cyc(0, 8'h00, 1, 0);
        chk("post_rst_underflow", 32'(underflow), 32'd1);
        chk("post_rst_count", 32'(count), 32'd0);
        cyc(0, 8'h00, 0, 1);
        chk("clr_underflow", 32'(underflow), 32'd0);

        // Fill, drain, and pointer wrap
        for (int i = 0; i < 4; i++) cyc(1, fill_vals[i], 0, 0);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_count", 32'(count), 32'd4);
        chk("fill_head", 32'(dout), 32'h11);
        cyc(0, 8'h00, 1, 0);
        chk("pop1_head", 32'(dout), 32'h22);
        cyc(0, 8'h00, 1, 0);
        chk("pop2_head", 32'(dout), 32'h33);
        cyc(1, 8'h55, 0, 0);
        cyc(1, 8'h66, 0, 0);
        chk("wrap_full", 32'(full), 32'd1);
        exp_seq = '{8'h33, 8'h44, 8'h55, 8'h66};
        foreach (exp_seq[i]) begin
            chk("drain_order", 32'(dout), 32'(exp_seq[i]));
            cyc(0, 8'h00, 1, 0);
        end
        chk("drain_empty", 32'(empty), 32'd1);

        // Overflow, then the full push+pop case
        for (int i = 0; i < 4; i++) cyc(1, fill_vals[i], 0, 0);
        cyc(1, 8'h99, 0, 0);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(count), 32'd4);
        chk("ovf_head", 32'(dout), 32'h11);
        cyc(0, 8'h00, 0, 1);
        chk("ovf_clear", 32'(overflow), 32'd0);
        cyc(1, 8'hAA, 1, 0);
        chk("fullpp_full", 32'(full), 32'd1);
        chk("fullpp_count", 32'(count), 32'd4);
        chk("fullpp_head", 32'(dout), 32'h22);
        chk("fullpp_ovf", 32'(overflow), 32'd0);
        exp_seq = '{8'h22, 8'h33, 8'h44, 8'hAA};
        foreach (exp_seq[i]) begin
            chk("fullpp_drain", 32'(dout), 32'(exp_seq[i]));
            cyc(0, 8'h00, 1, 0);
        end

        // Push and pop together on an empty FIFO
        cyc(1, 8'h5A, 1, 0);
        chk("emptypp_count", 32'(count), 32'd1);
        chk("emptypp_dout", 32'(dout), 32'h5A);
        chk("emptypp_unf", 32'(underflow), 32'd1);
        cyc(0, 8'h00, 1, 0);
        chk("emptypp_drained", 32'(empty), 32'd1);
        cyc(0, 8'h00, 1, 1);
        chk("clr_vs_set_unf", 32'(underflow), 32'd1);
        cyc(0, 8'h00, 0, 1);
        chk("clr_unf_final", 32'(underflow), 32'd0);

        // Steady streaming from count = 2
        exp_seq.delete();
        exp_seq.push_back(8'hA0); exp_seq.push_back(8'hA1);
        cyc(1, 8'hA0, 0, 0);
        cyc(1, 8'hA1, 0, 0);
        for (int k = 0; k < 20; k++) begin
            automatic logic [W-1:0] v = W'(8'hB0 + k);
            exp_seq.push_back(v);
            cyc(1, v, 1, 0);
            chk("stream_count", 32'(count), 32'd2);
            chk("stream_head", 32'(dout), 32'(exp_seq[k + 1]));
        end
        cyc(0, 8'h00, 1, 0);
        cyc(0, 8'h00, 1, 0);
        chk("stream_empty", 32'(empty), 32'd1);

        // Randomized traffic, with phases of alternating bias and occasional resets
        for (int i = 0; i < 3000; i++) begin
            automatic int pp = ((i / 250) % 2 == 1) ? 70 : 35;
            if (i % 700 == 350) begin
                do_reset_pulse();
            end else begin
                cyc($urandom_range(0, 99) < pp, W'($urandom),
                    $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 5);
            end
        end

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/byte_fifo.md
Name: byte_fifo

Overview:
- Small synchronous FIFO that buffers W-bit words from a producer, such as a bus or fetch unit, and feeds the datapath's load-enabled registers.
- The consumer reads the head word on dout and pops it in the cycle it latches it, typically by driving its en with pop.
- Show-ahead (first-word-fall-through) organisation: the head word is valid on dout whenever empty is low.

Parameters:
W, 8, data word width in bits.
DEPTH, 4, number of entries; must be a power of two and >= 2.
CW, $clog2(DEPTH)+1, width of the count output (derived, not overridden).

Ports:
clk  input  1  single clock; all state updates on its rising edge.
rst  input  1  reset, asynchronous, active-high; clears all state immediately.
din  input  W  write data, sampled when a push is accepted.
push  input  1  write request.
pop  input  1  read request; the head entry is removed when accepted.
clr_err  input  1  synchronous clear of the sticky error flags.
dout  output  W  head entry; defined only when empty=0.
empty  output  1  high when count==0.
full  output  1  high when count==DEPTH.
count  output  CW  number of stored entries, 0..DEPTH.
overflow  output  1  sticky; set by a rejected push.
underflow  output  1  sticky; set by a rejected pop.

Behaviour:
- Reset (rst=1, any time, asynchronous): rd_ptr=0, wr_ptr=0, count=0, all storage entries=0, dout=0, empty=1, full=0, overflow=0, underflow=0. Reset mid-operation discards all contents; the first cycle after release behaves as a fresh empty FIFO.
- Storage: DEPTH x W array. log2(DEPTH)-bit rd_ptr and wr_ptr wrap modulo DEPTH naturally, DEPTH-1 -> 0. count is held explicitly; it is not derived from the pointers.
- dout = mem[rd_ptr], combinational from the registered state. Write-to-dout latency: a word pushed into an empty FIFO at edge N appears on dout after edge N, with empty=0 in the same cycle.
- Accept rules, evaluated each rising edge:
  - push_ok = push & (~full | pop).
  - pop_ok = pop & ~empty.
- push_ok: mem[wr_ptr] <= din; wr_ptr <= wr_ptr+1.
- pop_ok: rd_ptr <= rd_ptr+1.
- count: +1 if push_ok & ~pop_ok; -1 if pop_ok & ~push_ok; otherwise unchanged.
- Simultaneous push+pop:
  - Not empty and not full: both accepted, count unchanged.
  - Full: both accepted; the write goes to the slot being vacated (wr_ptr==rd_ptr); full stays 1.
  - Empty: push accepted, pop rejected, underflow set, count -> 1. There is no bypass; dout shows the new word the next cycle.
- overflow <= 1 when push & ~push_ok. underflow <= 1 when pop & ~pop_ok.
- clr_err=1 clears both flags at the edge. If a new error occurs in the same cycle as clr_err, the set wins.
- Rejected operations leave the pointers, count and storage untouched.
- empty and full are decoded from the registered count, so both are glitch-free.

Test Plan:
- Reset state: assert rst mid-stream with 3 entries stored -> immediately count=0, empty=1, full=0, dout=0, flags=0. After release, pop -> underflow=1, count stays 0.
- Fill/drain with wrap: push 0x11,0x22,0x33,0x44 -> full=1, count=4. Pop twice -> dout shows 0x11, then 0x22, then 0x33. Push 0x55,0x66 -> pointers wrap. Drain -> order 0x33,0x44,0x55,0x66, then empty=1.
- Overflow: with full=1, push 0x99 without pop -> contents unchanged, overflow=1, count=4. Pulse clr_err -> overflow=0.
- Full push+pop: full with head 0x11, push 0xAA and pop in the same cycle -> full=1, count=4, dout=0x22, overflow=0. Tail after draining is 0xAA.
- Empty push+pop: empty, push 0x5A and pop together -> count=1, dout=0x5A next cycle, underflow=1. clr_err together with a new illegal pop -> underflow stays 1.
- Steady streaming: push and pop every cycle for 20 cycles starting from count=2 -> count stays 2 and output order exactly matches input order.
